// File: rtl/fish_sprite_engine.sv
// Fish sprite engine: ROM addressing, 2-cycle pixel pipeline with colour-key transparency,
// and the once-per-frame swim/bounce/caught/respawn FSM. Define FISH_MIRROR_EN to flip the sprite while swimming right.
module fish_sprite_engine #(
    parameter int unsigned X_LEFT        = 0,
    parameter int unsigned X_RIGHT       = 608,
    parameter int unsigned Y_POS         = 240,
    parameter int unsigned SPEED_DIV     = 4,
    parameter int unsigned CAUGHT_FRAMES = 60,
    parameter logic [11:0] KEY_COLOR     = 12'h0F0
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [9:0]  x,
    input  logic [9:0]  y,
    input  logic        video_on,
    input  logic        frame_tick,
    input  logic        hook_hit,
    output logic [3:0]  rom_row,
    output logic [4:0]  rom_col,
    input  logic [11:0] rom_data,
    output logic [11:0] rgb_out,
    output logic        fish_on,
    output logic [9:0]  fish_x,
    output logic        fish_dir,
    output logic        caught
);

    localparam int unsigned SW = (SPEED_DIV > 1) ? $clog2(SPEED_DIV) : 1;
    localparam int unsigned HW = (CAUGHT_FRAMES > 1) ? $clog2(CAUGHT_FRAMES) : 1;
    localparam logic [SW-1:0] STEP_LAST = SW'(SPEED_DIV - 1);
    localparam logic [HW-1:0] HOLD_LAST = HW'(CAUGHT_FRAMES - 1);
    localparam logic [9:0]    XL        = 10'(X_LEFT);
    localparam logic [9:0]    XR        = 10'(X_RIGHT);
    localparam logic [10:0]   Y_LO      = 11'(Y_POS);
    localparam logic [10:0]   Y_HI      = 11'(Y_POS + 15);

    typedef enum logic [1:0] {
        SWIM_RIGHT,
        SWIM_LEFT,
        CAUGHT,
        RESPAWN
    } state_t;

    state_t        r_state;
    logic [9:0]    r_fish_x;
    logic          r_fish_dir;
    logic [SW-1:0] r_step_cnt;
    logic [HW-1:0] r_hold_cnt;
    logic          r_caught;
    logic          r_s1_in_box;
    logic          r_s1_video_on;
    logic          r_fish_on;
    logic [11:0]   r_rgb;

    logic [10:0]   w_x11;
    logic [10:0]   w_y11;
    logic [10:0]   w_fx11;
    logic          w_in_box;
    logic [3:0]    w_row_off;
    logic [4:0]    w_col_off;
    logic [4:0]    w_col;
    logic          w_opaque;

    // 11-bit compare keeps fish_x+31 from wrapping near the right edge
    assign w_x11    = {1'b0, x};
    assign w_y11    = {1'b0, y};
    assign w_fx11   = {1'b0, r_fish_x};
    assign w_in_box = (w_x11 >= w_fx11) && (w_x11 <= w_fx11 + 11'd31) &&
                      (w_y11 >= Y_LO) && (w_y11 <= Y_HI);

    assign w_row_off = y[3:0] - Y_LO[3:0];
    assign w_col_off = x[4:0] - r_fish_x[4:0];

`ifdef FISH_MIRROR_EN
    assign w_col = r_fish_dir ? (5'd31 - w_col_off) : w_col_off;
`else
    assign w_col = w_col_off;
`endif

    assign rom_row = w_in_box ? w_row_off : '0;
    assign rom_col = w_in_box ? w_col : '0;

    assign w_opaque = r_s1_in_box && r_s1_video_on && (rom_data != KEY_COLOR);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_s1_in_box   <= 1'b0;
            r_s1_video_on <= 1'b0;
            r_fish_on     <= 1'b0;
            r_rgb         <= '0;
        end else begin
            r_s1_in_box   <= w_in_box;
            r_s1_video_on <= video_on;
            r_fish_on     <= w_opaque;
            r_rgb         <= w_opaque ? rom_data : 12'h000;
        end
    end

    // hook_hit takes priority over a coincident frame_tick in both swim states
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state    <= SWIM_RIGHT;
            r_fish_x   <= XL;
            r_fish_dir <= 1'b1;
            r_step_cnt <= '0;
            r_hold_cnt <= '0;
            r_caught   <= 1'b0;
        end else begin
            r_caught <= 1'b0;
            case (r_state)
                SWIM_RIGHT: begin
                    if (hook_hit) begin
                        r_state    <= CAUGHT;
                        r_caught   <= 1'b1;
                        r_hold_cnt <= '0;
                        r_step_cnt <= '0;
                    end else if (frame_tick) begin
                        if (r_step_cnt == STEP_LAST) begin
                            r_step_cnt <= '0;
                            if (r_fish_x == XR) begin
                                r_state    <= SWIM_LEFT;
                                r_fish_dir <= 1'b0;
                            end else begin
                                r_fish_x <= r_fish_x + 10'd1;
                            end
                        end else begin
                            r_step_cnt <= r_step_cnt + 1'b1;
                        end
                    end
                end
                SWIM_LEFT: begin
                    if (hook_hit) begin
                        r_state    <= CAUGHT;
                        r_caught   <= 1'b1;
                        r_hold_cnt <= '0;
                        r_step_cnt <= '0;
                    end else if (frame_tick) begin
                        if (r_step_cnt == STEP_LAST) begin
                            r_step_cnt <= '0;
                            if (r_fish_x == XL) begin
                                r_state    <= SWIM_RIGHT;
                                r_fish_dir <= 1'b1;
                            end else begin
                                r_fish_x <= r_fish_x - 10'd1;
                            end
                        end else begin
                            r_step_cnt <= r_step_cnt + 1'b1;
                        end
                    end
                end
                CAUGHT: begin
                    if (frame_tick) begin
                        if (r_hold_cnt == HOLD_LAST) begin
                            r_state    <= RESPAWN;
                            r_hold_cnt <= '0;
                        end else begin
                            r_hold_cnt <= r_hold_cnt + 1'b1;
                        end
                    end
                end
                RESPAWN: begin
                    r_fish_x   <= XL;
                    r_fish_dir <= 1'b1;
                    r_step_cnt <= '0;
                    r_state    <= SWIM_RIGHT;
                end
                default: r_state <= SWIM_RIGHT;
            endcase
        end
    end

    assign rgb_out  = r_rgb;
    assign fish_on  = r_fish_on;
    assign fish_x   = r_fish_x;
    assign fish_dir = r_fish_dir;
    assign caught   = r_caught;

endmodule

// File: tb/tb_fish_sprite_engine.sv
// Scoreboard bench for fish_sprite_engine: pixel expectations are queued at issue and
// popped by a monitor two cycles later; FSM behaviour is checked with directed frame ticks.
module tb_fish_sprite_engine;

    localparam logic [11:0] KEY = 12'h0F0;
`ifdef FISH_MIRROR_EN
    localparam bit MIR = 1'b1;
`else
    localparam bit MIR = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset;
    logic [9:0]  x;
    logic [9:0]  y;
    logic        video_on;
    logic        frame_tick;
    logic        hook_hit;
    logic [3:0]  rom_row;
    logic [4:0]  rom_col;
    logic [11:0] rom_data = '0;
    logic [11:0] rgb_out;
    logic        fish_on;
    logic [9:0]  fish_x;
    logic        fish_dir;
    logic        caught;

    typedef struct packed {
        logic        on;
        logic [11:0] rgb;
    } pix_t;

    pix_t       sb[$];
    logic       issued = 1'b0;
    logic [1:0] vpipe  = '0;
    int         errors = 0;
    int         checks = 0;
    int         exp_fx;
    bit         exp_dir;

    always #5 clk = ~clk;

    fish_sprite_engine #(
        .X_LEFT(0),
        .X_RIGHT(608),
        .Y_POS(240),
        .SPEED_DIV(4),
        .CAUGHT_FRAMES(60),
        .KEY_COLOR(12'h0F0)
    ) dut (
        .clk(clk),
        .reset(reset),
        .x(x),
        .y(y),
        .video_on(video_on),
        .frame_tick(frame_tick),
        .hook_hit(hook_hit),
        .rom_row(rom_row),
        .rom_col(rom_col),
        .rom_data(rom_data),
        .rgb_out(rgb_out),
        .fish_on(fish_on),
        .fish_x(fish_x),
        .fish_dir(fish_dir),
        .caught(caught)
    );

    // ROM image: every 4th column holds the key colour, others encode row/col
    function automatic logic [11:0] rom_f(input logic [3:0] r, input logic [4:0] c);
        if (c[1:0] == 2'b11) return KEY;
        return {r, 3'b000, c};
    endfunction

    always @(posedge clk) rom_data <= rom_f(rom_row, rom_col);

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic pixel(input int px, input int py, input bit von);
        int          inb;
        int          roff;
        int          coff;
        int          col;
        logic [11:0] d;
        pix_t        e;
        @(posedge clk);
        #2;
        x = 10'(px);
        y = 10'(py);
        video_on = von;
        inb  = (px >= exp_fx && px <= exp_fx + 31 && py >= 240 && py <= 255) ? 1 : 0;
        roff = (inb != 0) ? py - 240 : 0;
        coff = px - exp_fx;
        col  = (inb != 0) ? ((MIR && exp_dir) ? 31 - coff : coff) : 0;
        d    = rom_f(4'(roff), 5'(col));
        e.on  = (inb != 0) && von && (d != KEY);
        e.rgb = e.on ? d : 12'h000;
        sb.push_back(e);
        issued = 1'b1;
        #1;
        chk("rom_row", int'(rom_row), roff);
        chk("rom_col", int'(rom_col), col);
    endtask

    task automatic ticks(input int n);
        @(posedge clk);
        #2 frame_tick = 1'b1;
        repeat (n) @(posedge clk);
        #2 frame_tick = 1'b0;
    endtask

    task automatic drain();
        #2 video_on = 1'b0;
        repeat (4) @(posedge clk);
        #2;
        chk("sb_drain", sb.size(), 0);
    endtask

    initial begin : monitor
        pix_t e;
        forever begin
            @(negedge clk);
            if (vpipe[1]) begin
                if (sb.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL pix_queue: got empty expected entry at %0t", $time);
                end else begin
                    e = sb.pop_front();
                    chk("fish_on", int'(fish_on), int'(e.on));
                    chk("rgb_out", int'(rgb_out), int'(e.rgb));
                end
            end
            vpipe  = {vpipe[0], issued};
            issued = 1'b0;
        end
    end

    initial begin : watchdog
        #1_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        reset = 1'b1; x = '0; y = '0; video_on = 1'b0;
        frame_tick = 1'b0; hook_hit = 1'b0;
        exp_fx = 0; exp_dir = 1'b1;
        repeat (3) @(posedge clk);
        #2;
        chk("rst_fish_x", int'(fish_x), 0);
        chk("rst_fish_dir", int'(fish_dir), 1);
        chk("rst_caught", int'(caught), 0);
        chk("rst_fish_on", int'(fish_on), 0);
        chk("rst_rgb", int'(rgb_out), 0);
        reset = 1'b0;

        for (int i = 0; i < 640; i++) pixel(i, 245, i != 20);
        pixel(5, 239, 1'b1);
        pixel(5, 240, 1'b1);
        pixel(5, 255, 1'b1);
        pixel(5, 256, 1'b1);
        pixel(31, 250, 1'b1);
        pixel(32, 250, 1'b1);
        pixel(2, 245, 1'b0);
        drain();

        for (int k = 1; k <= 8; k++) begin
            ticks(1);
            chk("step_fish_x", int'(fish_x), k / 4);
        end
        ticks(2432 - 8);
        chk("right_edge_x", int'(fish_x), 608);
        chk("right_edge_dir", int'(fish_dir), 1);
        for (int k = 1; k <= 4; k++) begin
            ticks(1);
            chk("bounce_x", int'(fish_x), 608);
            chk("bounce_dir", int'(fish_dir), (k == 4) ? 0 : 1);
        end
        for (int k = 1; k <= 4; k++) begin
            ticks(1);
            chk("left_step_x", int'(fish_x), (k == 4) ? 607 : 608);
        end

        exp_fx = 607; exp_dir = 1'b0;
        pixel(606, 250, 1'b1);
        pixel(607, 250, 1'b1);
        pixel(610, 250, 1'b1);
        pixel(637, 250, 1'b1);
        pixel(638, 250, 1'b1);
        pixel(639, 250, 1'b1);
        drain();

        ticks(2028);
        chk("at100_x", int'(fish_x), 100);
        chk("at100_dir", int'(fish_dir), 0);
        ticks(3);
        chk("pre_hook_x", int'(fish_x), 100);

        @(posedge clk);
        #2 hook_hit = 1'b1; frame_tick = 1'b1;
        @(posedge clk);
        #2 hook_hit = 1'b0; frame_tick = 1'b0;
        chk("caught_pulse", int'(caught), 1);
        chk("caught_x", int'(fish_x), 100);
        @(posedge clk);
        #2 chk("caught_one_cycle", int'(caught), 0);

        @(posedge clk);
        #2 hook_hit = 1'b1;
        @(posedge clk);
        #2 hook_hit = 1'b0;
        chk("no_second_pulse", int'(caught), 0);
        @(posedge clk);
        #2 chk("no_second_pulse2", int'(caught), 0);

        ticks(59);
        chk("frozen_x", int'(fish_x), 100);
        chk("frozen_dir", int'(fish_dir), 0);
        ticks(1);
        chk("respawn_state_x", int'(fish_x), 100);
        @(posedge clk);
        #2;
        chk("respawn_x", int'(fish_x), 0);
        chk("respawn_dir", int'(fish_dir), 1);

        ticks(12);
        chk("after_respawn_x", int'(fish_x), 3);
        @(posedge clk);
        #2 hook_hit = 1'b1;
        @(posedge clk);
        #2 hook_hit = 1'b0;
        chk("caught2_pulse", int'(caught), 1);
        ticks(30);
        chk("caught2_x", int'(fish_x), 3);

        @(posedge clk);
        #2 x = 10'd4; y = 10'd245; video_on = 1'b1;
        repeat (2) @(posedge clk);
        #2;
        chk("pre_rst_fish_on", int'(fish_on), 1);
        chk("pre_rst_rgb", int'(rgb_out), int'(rom_f(4'd5, MIR ? 5'd30 : 5'd1)));

        reset = 1'b1;
        #1;
        chk("async_fish_x", int'(fish_x), 0);
        chk("async_fish_dir", int'(fish_dir), 1);
        chk("async_caught", int'(caught), 0);
        chk("async_fish_on", int'(fish_on), 0);
        chk("async_rgb", int'(rgb_out), 0);
        @(posedge clk);
        #2 chk("rst_hold_on1", int'(fish_on), 0);
        @(posedge clk);
        #2 chk("rst_hold_on2", int'(fish_on), 0);
        video_on = 1'b0;
        reset = 1'b0;

        ticks(4);
        chk("post_rst_step_x", int'(fish_x), 1);
        chk("post_rst_dir", int'(fish_dir), 1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/fish_sprite_engine.md
Name: fish_sprite_engine

Overview:
- Sits directly downstream of the 16x32 fish sprite ROM and upstream of the VGA RGB mux.
- Drives the ROM's row/col address from the current VGA pixel coordinate and the fish position.
- Aligns the ROM's 1-cycle registered read with the pixel pipeline and applies colour-key transparency.
- Runs the fish's swim/bounce/caught/respawn movement FSM, updated once per frame.

Parameters:
- X_LEFT, 0, minimum sprite left-edge x position.
- X_RIGHT, 608, maximum sprite left-edge x position (640-32).
- Y_POS, 240, sprite top-edge y position (fixed row of water).
- SPEED_DIV, 4, frame ticks per 1-pixel step (slow fish); must be >=1.
- CAUGHT_FRAMES, 60, frame ticks the fish stays frozen after being caught.
- KEY_COLOR, 12'h0F0, transparent colour in ROM data.

Ports:
- clk  in  1  pixel clock
- reset  in  1  async active-high reset
- x  in  10  current pixel x from VGA sync
- y  in  10  current pixel y from VGA sync
- video_on  in  1  active-video flag, same cycle as x/y
- frame_tick  in  1  one-cycle pulse at start of vertical blank
- hook_hit  in  1  one-cycle pulse: hook overlaps fish
- rom_row  out  4  ROM row address (combinational)
- rom_col  out  5  ROM col address (combinational)
- rom_data  in  12  ROM colour_data, valid 1 cycle after address
- rgb_out  out  12  fish pixel colour, registered
- fish_on  out  1  fish pixel opaque and visible, registered
- fish_x  out  10  current sprite left-edge x
- fish_dir  out  1  1 = swimming right, 0 = swimming left
- caught  out  1  one-cycle pulse on entering CAUGHT

Behaviour:
- Clock and reset: one clock, clk. Reset is asynchronous and active-high, named reset.
- Reset values:
  - state = SWIM_RIGHT, fish_x = X_LEFT, fish_dir = 1.
  - step_cnt = 0, hold_cnt = 0.
  - rgb_out = 0, fish_on = 0, caught = 0.
  - All pipeline flags are cleared.
- in_box (combinational): x in [fish_x, fish_x+31] and y in [Y_POS, Y_POS+15]. Use 11-bit compare so fish_x+31 does not wrap.
- Address generation:
  - When in_box: rom_row = y - Y_POS, col_off = x - fish_x (5 bits).
  - When not in_box: rom_row = 0, rom_col = 0.
  - rom_col = col_off (subject to mirroring; see Optional Feature).
- Pipeline, with x/y presented at cycle t:
  - t+1: in_box and video_on are registered to stage-1 flags; rom_data is valid.
  - t+2: fish_on <= stage1_in_box & stage1_video_on & (rom_data != KEY_COLOR); rgb_out <= rom_data if that condition holds, else 12'h000.
  - Total latency is 2 cycles; fully pipelined, one pixel per cycle.
- FSM, which acts only on frame_tick except where noted:
  - SWIM_RIGHT (fish_dir=1):
    - On a tick, if step_cnt == SPEED_DIV-1, then step_cnt <= 0 and: if fish_x == X_RIGHT, go to SWIM_LEFT (x unchanged); else fish_x += 1.
    - Otherwise step_cnt += 1.
  - SWIM_LEFT (fish_dir=0): mirror of SWIM_RIGHT. Bounce at X_LEFT to SWIM_RIGHT; otherwise fish_x -= 1.
  - hook_hit in either SWIM state (any cycle):
    - Go to CAUGHT; caught = 1 for exactly that next cycle.
    - hold_cnt <= 0, step_cnt <= 0.
    - If frame_tick arrives in the same cycle, hook_hit wins and no move occurs.
  - CAUGHT:
    - fish_x frozen; sprite still drawn; hook_hit ignored.
    - hold_cnt increments per tick.
    - The tick on which hold_cnt == CAUGHT_FRAMES-1 goes to RESPAWN.
  - RESPAWN (single cycle, no tick needed): fish_x <= X_LEFT, fish_dir <= 1, step_cnt <= 0, then go to SWIM_RIGHT.
- Position changes only on frame_tick/RESPAWN, so no mid-frame tearing except a 1-cycle RESPAWN during blank.
- Reset mid-frame or mid-CAUGHT returns immediately to reset values; the pipeline flags are cleared, so no stale pixel is emitted.

Optional Feature:
- Macro: FISH_MIRROR_EN.
- Defined: the ROM image faces left. While fish_dir = 1, rom_col = 31 - col_off, so the fish faces its travel direction.
- Undefined: rom_col = col_off always; the image is never flipped.

Test Plan:
- Reset, then sweep x=0..639 at y=Y_POS+5 -> fish_on only within x in [0,31], 2 cycles after x; rom_row=5; fish_on=0 wherever rom_data==12'h0F0.
- SPEED_DIV=4, 8 frame_ticks -> fish_x goes 0->2; fish_x changes only on the 4th and 8th tick.
- Force fish_x=X_RIGHT while SWIM_RIGHT, then 4 ticks -> fish_dir=0 and fish_x stays 608; 4 more ticks -> fish_x=607.
- hook_hit coincident with the step tick at fish_x=100 -> caught pulses 1 cycle, fish_x stays 100; after 60 ticks -> fish_x=0, fish_dir=1; hook_hit during CAUGHT produces no second pulse.
- FISH_MIRROR_EN defined, fish_dir=1, x=fish_x+2 -> rom_col=29; undefined -> rom_col=2.
- Assert reset during CAUGHT with hold_cnt=30 -> all outputs return to reset values asynchronously; fish_on=0 on the next two cycles.
